// File: rtl/gauss_blur_stripe_pkg.sv
// ============================================================================
// blur_pkg : kernel weights, divisors and FSM encoding for gauss_blur_stripe
// Revision : 1.0
// ============================================================================
`default_nettype none

package blur_pkg;

    localparam int SUM_W = 17;
    localparam int DIV5  = 324;
    localparam int DIV3  = 16;

    localparam logic [4:0][3:0] W5 = {4'd1, 4'd4, 4'd8, 4'd4, 4'd1};
    localparam logic [2:0][3:0] W3 = {4'd1, 4'd2, 4'd1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACC   = 2'd2,
        NORM  = 2'd3
    } state_t;

    // Tap weight on a 5-wide window; the 3x3 kernel occupies taps 1..3.
    function automatic logic [3:0] kern_w(input logic [2:0] tap, input logic m3);
        logic [3:0] w;
        w = '0;
        if (!m3) begin
            case (tap)
                3'd0:    w = W5[0];
                3'd1:    w = W5[1];
                3'd2:    w = W5[2];
                3'd3:    w = W5[3];
                3'd4:    w = W5[4];
                default: w = '0;
            endcase
        end else begin
            case (tap)
                3'd1:    w = W3[0];
                3'd2:    w = W3[1];
                3'd3:    w = W3[2];
                default: w = '0;
            endcase
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gauss_blur_stripe_if.sv
// ============================================================================
// gauss_blur_stripe_if : row handshake and blurred-row output bundle
// Revision : 1.0
// ============================================================================
`default_nettype none

interface gauss_blur_stripe_if #(
    parameter int PIX_W    = 8,
    parameter int OUT_COLS = 16
);
    localparam int IN_COLS = OUT_COLS + 4;

    logic                      row_valid;
    logic                      row_ready;
    logic                      frame_start;
    logic                      mode_3x3;
    logic [IN_COLS*PIX_W-1:0]  row_in;
    logic [OUT_COLS*PIX_W-1:0] blur_out;
    logic                      out_valid;
    logic                      busy;

    modport master (
        output row_valid, frame_start, mode_3x3, row_in,
        input  row_ready, blur_out, out_valid, busy
    );

    modport slave (
        input  row_valid, frame_start, mode_3x3, row_in,
        output row_ready, blur_out, out_valid, busy
    );

endinterface

`default_nettype wire

// File: rtl/gauss_blur_stripe_col_mac.sv
// ============================================================================
// blur_col_mac : per-column accumulator of row-weighted horizontal sums
// Revision : 1.0
// ============================================================================
`default_nettype none

module blur_col_mac
    import blur_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [5*PIX_W-1:0]       i_pix,
    input  logic [2:0]               i_k,
    input  logic                     i_mode,
    input  logic                     i_clr,
    input  logic                     i_en,
    output logic [PIX_W+SUM_W-9:0]   o_sum
);

    localparam int c_hsum_w = PIX_W + 5;
    localparam int c_sum_w  = PIX_W + SUM_W - 8;

    logic [c_hsum_w-1:0] w_hsum;
    logic [3:0]          w_wr;
    logic [c_sum_w-1:0]  w_term;
    logic [c_sum_w-1:0]  r_acc;

    always_comb begin
        w_hsum = '0;
        for (int j = 0; j < 5; j++) begin
            w_hsum = w_hsum + c_hsum_w'(kern_w(3'(j), i_mode)) *
                              c_hsum_w'(i_pix[j*PIX_W +: PIX_W]);
        end
    end

    // 3x3 walks history rows h1..h3, so its row weight is offset by one tap.
    assign w_wr   = kern_w(i_mode ? i_k + 3'd1 : i_k, i_mode);
    assign w_term = c_sum_w'(w_wr) * c_sum_w'(w_hsum);

    // Exposes the post-update sum so the final row can be normalised on the same edge.
    assign o_sum  = r_acc + (i_en ? w_term : '0);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gauss_blur_stripe.sv
// ============================================================================
// gauss_blur_stripe : 5-row history, separable 5x5 / 3x3 Gaussian per column
// Revision : 1.0
// ============================================================================
`default_nettype none

module gauss_blur_stripe
    import blur_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int OUT_COLS = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    gauss_blur_stripe_if.slave bus
);

    localparam int c_in_w  = (OUT_COLS + 4) * PIX_W;
    localparam int c_sum_w = PIX_W + SUM_W - 8;

    state_t                    r_state;
    logic [2:0]                r_k;
    logic                      r_m3;
    logic                      r_ready;
    logic                      r_out_valid;
    logic [OUT_COLS*PIX_W-1:0] r_blur;
    logic [c_in_w-1:0]         r_hist [5];

    logic                      w_accept;
    logic [2:0]                w_klast;
    logic [2:0]                w_ridx;
    logic [c_in_w-1:0]         w_krow;
    logic [c_sum_w-1:0]        w_sum [OUT_COLS];
    logic [OUT_COLS*PIX_W-1:0] w_blur;

    assign w_accept = bus.row_valid && r_ready;
    assign w_klast  = r_m3 ? 3'd2 : 3'd4;
    assign w_ridx   = r_m3 ? r_k + 3'd1 : r_k;

    always_comb begin
        w_krow = r_hist[0];
        case (w_ridx)
            3'd1:    w_krow = r_hist[1];
            3'd2:    w_krow = r_hist[2];
            3'd3:    w_krow = r_hist[3];
            3'd4:    w_krow = r_hist[4];
            default: w_krow = r_hist[0];
        endcase
    end

    generate
        for (genvar c = 0; c < OUT_COLS; c++) begin : g_col
            blur_col_mac #(.PIX_W(PIX_W)) u_mac (
                .clk    (clk),
                .n_rst  (n_rst),
                .i_pix  (w_krow[c*PIX_W +: 5*PIX_W]),
                .i_k    (r_k),
                .i_mode (r_m3),
                .i_clr  (r_state == SHIFT),
                .i_en   (r_state == ACC),
                .o_sum  (w_sum[c])
            );
            assign w_blur[c*PIX_W +: PIX_W] = r_m3 ? PIX_W'(w_sum[c] / c_sum_w'(DIV3))
                                                   : PIX_W'(w_sum[c] / c_sum_w'(DIV5));
        end
    endgenerate

    // History is written on the accept edge so row_in need not be held into SHIFT.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_m3        <= 1'b0;
            r_ready     <= 1'b1;
            r_out_valid <= 1'b0;
            r_blur      <= '0;
            for (int i = 0; i < 5; i++) r_hist[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_m3      <= bus.mode_3x3;
                        r_hist[0] <= bus.row_in;
                        for (int i = 1; i < 5; i++)
                            r_hist[i] <= bus.frame_start ? bus.row_in : r_hist[i-1];
                        r_ready   <= 1'b0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_k     <= '0;
                    r_state <= ACC;
                end
                ACC: begin
                    if (r_k == w_klast) begin
                        r_blur      <= w_blur;
                        r_out_valid <= 1'b1;
                        r_state     <= NORM;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                NORM: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.row_ready = r_ready;
    assign bus.busy      = !r_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.blur_out  = r_blur;

endmodule

`default_nettype wire
